imem_loader: RTL and testbench

//  Program-load engine that fills the 32-bit instruction memory the pipelined CPU fetches from.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_word_packer.sv | 65 ++++++
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory program loader.
//   - state_t        : loader FSM state encoding
//   - HDR_BYTES      : number of length-header bytes at the start of a frame
//   - BYTE_IDX_W     : width of the byte-within-word index used by the packer
//   - BYTES_PER_WORD : bytes packed into one 32-bit imem word
//   - hold_for()     : whether the CPU must be held off imem in a given state
// ----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CKSUM  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTE_IDX_W     = 2;
  localparam int BYTES_PER_WORD = 4;

  // The CPU may only fetch once nothing is loading: idle or a finished good load.
  // A failed load keeps it held so it never runs a partial image.
  function automatic logic hold_for(input state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// ----------------------------------------------------------------------------
// imem_word_packer
// Packs a byte stream big-endian (first byte -> bits 31:24) into 32-bit words.
// Ports:
//   clk1        in   clock (posedge)
//   rst         in   asynchronous active-high reset
//   clear       in   restart packing at byte 0 (new load)
//   byte_valid  in   a byte is being consumed this cycle
//   byte_data   in   the byte
//   byte_last   out  the next consumed byte completes a word
//   word_valid  out  one-cycle pulse, cycle after the 4th byte of a word
//   word_data   out  packed word (valid while word_valid is high)
// ----------------------------------------------------------------------------
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk1,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]           shift_q, shift_d;
  logic                  valid_q, valid_d;

  assign byte_last = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    if (clear) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[23:0], byte_data};
      // index wraps naturally from 3 back to 0
      idx_d   = idx_q + BYTE_IDX_W'(1);
      valid_d = byte_last;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  // In the pulse cycle the shift register holds exactly the completed word;
  // a following byte only shifts in at the end of that cycle.
  assign word_valid = valid_q;
  assign word_data  = shift_q;

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Program-load engine filling the CPU instruction memory from a byte stream.
// Frame: LEN_HI, LEN_LO (word count N, big-endian), N x 4 data bytes MSB
// first, then (optionally) one checksum byte.
// Optional feature macro: IMEM_LOADER_CKSUM_EN -- when defined a trailing
// checksum byte (XOR of all prior frame bytes) is expected and verified.
// Ports:
//   clk1          in   clock (posedge)
//   rst           in   asynchronous active-high reset
//   start         in   begin a load (only in IDLE / DONE / ERR)
//   in_valid      in   byte valid
//   in_data       in   byte
//   in_ready      out  byte accepted when in_valid & in_ready
//   mem_we        out  imem write strobe, one cycle per word
//   mem_addr      out  imem word address
//   mem_wdata     out  imem write data
//   cpu_hold      out  CPU must not fetch
//   done          out  last load completed OK
//   error         out  last load failed
//   words_loaded  out  words written in current/last load
// ----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int LEN_W = 8 * HDR_BYTES;
  // Largest word count that fits between BASE_ADDR and the end of imem.
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(DEPTH - BASE_ADDR);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        xor_q, xor_d;
  logic [15:0]       words_in_q, words_in_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       loaded_q, loaded_d;

  logic              accept;
  logic              start_ok;
  logic              pk_byte_valid;
  logic              pk_last;

  assign accept        = in_valid && in_ready;
  assign pk_byte_valid = accept && (state_q == ST_DATA);

  // Ready only in byte-consuming states. In DATA it drops once every data
  // byte of the frame has been taken, so a byte arriving while the final
  // word is still being written is never mistaken for frame data.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_CKSUM: in_ready = 1'b1;
      ST_DATA:                        in_ready = (words_in_q != len_q);
      default:                        in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    xor_d      = xor_q;
    words_in_d = words_in_q;
    addr_d     = addr_q;
    loaded_d   = loaded_q;
    start_ok   = 1'b0;

    if (mem_we) begin
      addr_d   = addr_q + ADDR_W'(1);
      loaded_d = loaded_q + 16'd1;
    end

    // Running checksum covers header and data, never the checksum byte itself.
    if (accept && (state_q != ST_CKSUM)) begin
      xor_d = xor_q ^ in_data;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          start_ok   = 1'b1;
          state_d    = ST_LEN_HI;
          len_d      = '0;
          xor_d      = '0;
          words_in_d = '0;
          addr_d     = ADDR_W'(BASE_ADDR);
          loaded_d   = '0;
        end
      end

      ST_LEN_HI: begin
        if (accept) begin
          len_d   = {len_q[LEN_W-9:0], in_data};
          state_d = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (accept) begin
          len_d = {len_q[LEN_W-9:0], in_data};
          if ({1'b0, len_d} > MAX_WORDS) begin
            state_d = ST_ERR;
          end else if (len_d == '0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept && pk_last) begin
          words_in_d = words_in_q + 16'd1;
`ifdef IMEM_LOADER_CKSUM_EN
          // The final word's write lands in the first CKSUM cycle.
          if (words_in_q + 16'd1 == len_q) begin
            state_d = ST_CKSUM;
          end
`endif
        end
`ifndef IMEM_LOADER_CKSUM_EN
        // Finish only after the last word has actually been written.
        if (mem_we && (loaded_q + 16'd1 == len_q)) begin
          state_d = ST_DONE;
        end
`endif
      end

      ST_CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
        if (accept) begin
          state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
        end
`else
        // Not reachable without the checksum feature; fail safe.
        state_d = ST_ERR;
`endif
      end

      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      xor_q      <= '0;
      words_in_q <= '0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      loaded_q   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      words_in_q <= words_in_d;
      addr_q     <= addr_d;
      loaded_q   <= loaded_d;
    end
  end

  imem_word_packer u_packer (
    .clk1       (clk1),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (pk_byte_valid),
    .byte_data  (in_data),
    .byte_last  (pk_last),
    .word_valid (mem_we),
    .word_data  (mem_wdata)
  );

  assign mem_addr     = addr_q;
  assign words_loaded = loaded_q;
  assign cpu_hold     = hold_for(state_q);
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
// Scoreboard bench: each data word sent pushes its expected imem write; a
// monitor pops and compares on every mem_we. Status outputs are checked
// directly after each frame. Works with or without IMEM_LOADER_CKSUM_EN.
// ----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  always #5 clk1 = ~clk1;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(1024), .BASE_ADDR(0)) dut (
    .clk1         (clk1),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               exp_q[$];
  wr_t               mon_e;
  int                tests = 0;
  int                fails = 0;
  int                we_count = 0;
  int                we_base;
  logic [7:0]        cks;
  logic [ADDR_W-1:0] next_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT performs must match the next expected one.
  always @(negedge clk1) begin
    if (mem_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %h required no write",
                 mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("write_data", mem_wdata, mon_e.data);
        $display("[TB] write addr=%0d data=%h", mem_addr, mem_wdata);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks start and end at posedge+1.
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk1);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; ; n++) begin
      @(negedge clk1);
      if (in_ready) break;
      if (n >= 50) begin
        tests++;
        fails++;
        $display("[TB] FAIL byte_accept_timeout: byte %h in_ready 0 required 1", b);
        break;
      end
    end
    @(posedge clk1);
    #1;
    in_valid = 1'b0;
    cks = cks ^ b;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk1);
    #1;
    start = 1'b0;
  endtask

  task automatic begin_load();
    pulse_start();
    cks       = 8'h00;
    next_addr = '0;
    we_base   = we_count;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    exp_q.push_back('{addr: next_addr, data: w});
    next_addr = next_addr + 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic send_cksum(input logic good);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(good ? cks : 8'hFF, 0);
`else
    if (good) idle(0);
`endif
  endtask

  task automatic wait_end(input string name);
    for (int n = 0; ; n++) begin
      @(negedge clk1);
      if (done || error) break;
      if (n >= 80) begin
        tests++;
        fails++;
        $display("[TB] FAIL %s_timeout: done/error never rose, required 1", name);
        break;
      end
    end
    @(posedge clk1);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cks      = 8'h00;
    next_addr = '0;
    we_base  = 0;
    repeat (2) @(posedge clk1);
    #1;
    // Reset state
    check("rst_in_ready",  32'(in_ready), 32'd0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    check("rst_cpu_hold",  32'(cpu_hold), 32'd0);
    check("rst_done",      32'(done), 32'd0);
    check("rst_error",     32'(error), 32'd0);
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_words",     32'(words_loaded), 32'd0);
    rst = 1'b0;
    idle(2);

    // T2: two-word frame
    begin_load();
    check("t2_hold_on_start", 32'(cpu_hold), 32'd1);
    check("t2_ready_len_hi",  32'(in_ready), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h11223344, 0);
    send_word(32'hAABBCCDD, 0);
    send_cksum(1'b1);
    wait_end("t2");
    check("t2_done",     32'(done), 32'd1);
    check("t2_error",    32'(error), 32'd0);
    check("t2_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t2_words",    32'(words_loaded), 32'd2);
    check("t2_mem_addr", 32'(mem_addr), 32'd2);
    check("t2_we_count", 32'(we_count - we_base), 32'd2);
    // Bytes offered in DONE are not consumed
    in_valid = 1'b1;
    in_data  = 8'h5A;
    idle(0);
    in_valid = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    check("done_ready_low", 32'(in_ready), 32'd0);
    check("done_holds",     32'(done), 32'd1);
    in_valid = 1'b0;

    // T1: reset mid-DATA after one word is written
    begin_load();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h11223344, 0);
    send_byte(8'hAA, 0);
    idle(2);
    check("t1_pre_words", 32'(words_loaded), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_in_ready", 32'(in_ready), 32'd0);
    check("t1_mem_we",   32'(mem_we), 32'd0);
    check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t1_done",     32'(done), 32'd0);
    check("t1_error",    32'(error), 32'd0);
    check("t1_mem_addr", 32'(mem_addr), 32'd0);
    check("t1_wdata",    mem_wdata, 32'd0);
    check("t1_words",    32'(words_loaded), 32'd0);
    @(posedge clk1);
    #1;
    rst = 1'b0;
    idle(1);

    // T3: length 0x0401 exceeds DEPTH
    begin_load();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    idle(3);
    check("t3_error",    32'(error), 32'd1);
    check("t3_done",     32'(done), 32'd0);
    check("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_no_write", 32'(we_count - we_base), 32'd0);

    // Boundary: length 0x0400 exactly fills imem and is accepted
    begin_load();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    idle(1);
    check("max_len_error", 32'(error), 32'd0);
    check("max_len_ready", 32'(in_ready), 32'd1);
    check("max_len_hold",  32'(cpu_hold), 32'd1);
    #2;
    rst = 1'b1;
    @(posedge clk1);
    #1;
    rst = 1'b0;
    idle(1);

    // Zero-length frame
    begin_load();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_cksum(1'b1);
    wait_end("zero_len");
    check("zero_done",  32'(done), 32'd1);
    check("zero_words", 32'(words_loaded), 32'd0);
    check("zero_hold",  32'(cpu_hold), 32'd0);

`ifdef IMEM_LOADER_CKSUM_EN
    // T4: bad checksum
    begin_load();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h11223344, 0);
    send_word(32'hAABBCCDD, 0);
    send_cksum(1'b0);
    wait_end("t4");
    check("t4_error", 32'(error), 32'd1);
    check("t4_done",  32'(done), 32'd0);
    check("t4_hold",  32'(cpu_hold), 32'd1);
    check("t4_words", 32'(words_loaded), 32'd2);
`endif

    // T5: 16 words with random byte gaps
    begin_load();
    send_byte(8'h00, 2);
    send_byte(8'h10, 3);
    for (int i = 0; i < 16; i++) begin
      send_word({8'(i), 8'(~i), 8'(i + 16), 8'hA5}, 3);
    end
    send_cksum(1'b1);
    wait_end("t5");
    check("t5_done",     32'(done), 32'd1);
    check("t5_we_count", 32'(we_count - we_base), 32'd16);
    check("t5_words",    32'(words_loaded), 32'd16);
    check("t5_mem_addr", 32'(mem_addr), 32'd16);

    // T6: start during DATA ignored
    begin_load();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(32'hDEADBEEF, 0);
    pulse_start();
    check("t6_ready_after_start", 32'(in_ready), 32'd1);
    check("t6_words_after_start", 32'(words_loaded), 32'd1);
    send_word(32'h01234567, 1);
    send_word(32'h89ABCDEF, 0);
    send_cksum(1'b1);
    wait_end("t6a");
    check("t6_done",  32'(done), 32'd1);
    check("t6_words", 32'(words_loaded), 32'd3);

    // T6: restart from ERR
    begin_load();
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    idle(2);
    check("t6_err", 32'(error), 32'd1);
    begin_load();
    check("t6_err_cleared", 32'(error), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hCAFEF00D, 0);
    send_cksum(1'b1);
    wait_end("t6b");
    check("t6b_done",  32'(done), 32'd1);
    check("t6b_error", 32'(error), 32'd0);
    check("t6b_words", 32'(words_loaded), 32'd1);
    check("t6b_hold",  32'(cpu_hold), 32'd0);

    idle(2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
